// File: rtl/tx_frame_scheduler.sv
// tx_frame_scheduler
// Drives the DCSK chip counter: takes a multi-frame transmit request, holds the
// spreading factor steady for the whole request, waits for enough chaos samples,
// strobes the chip counter, then follows each frame to its end with a guard gap
// between frames. Completion, abort and timeout are reported as one-cycle pulses.
module tx_frame_scheduler #(
  parameter int LVL_W      = 8,
  parameter int MIN_CHAOS  = 16,
  parameter int WAIT_TMO   = 1024,
  parameter int GAP_CYCLES = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [1:0]       i_req_sf,
  input  logic [7:0]       i_req_frames,
  input  logic             i_abort,
  input  logic [LVL_W-1:0] i_chaos_level,
  input  logic             i_sending,
  output logic             o_send,
  output logic [1:0]       o_spreading_factor,
  output logic             o_busy,
  output logic             o_frame_done,
  output logic             o_req_done,
  output logic             o_err_timeout,
  output logic [7:0]       o_frames_left
);

  localparam int WAIT_W = $clog2(WAIT_TMO + 1);
  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_TMO - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [LVL_W-1:0]  LVL_MIN   = LVL_W'(MIN_CHAOS);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_CHAOS,
    SEND,
    ACK,
    BUSY,
    GAP
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic              ack_cnt;
  logic              abort_pend;
  logic              sending_q;

  // Request sequencer: every output is a register updated alongside the state,
  // and any path back to IDLE drops ready for one cycle while o_req_done pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state              <= IDLE;
      o_req_ready        <= 1'b1;
      o_send             <= 1'b0;
      o_busy             <= 1'b0;
      o_frame_done       <= 1'b0;
      o_req_done         <= 1'b0;
      o_err_timeout      <= 1'b0;
      o_frames_left      <= 8'd0;
      o_spreading_factor <= 2'b00;
      wait_cnt           <= '0;
      gap_cnt            <= '0;
      ack_cnt            <= 1'b0;
      abort_pend         <= 1'b0;
      sending_q          <= 1'b0;
    end else begin
      o_send        <= 1'b0;
      o_frame_done  <= 1'b0;
      o_req_done    <= 1'b0;
      o_err_timeout <= 1'b0;
      sending_q     <= i_sending;
      case (state)
        IDLE: begin
          if (i_req_valid && o_req_ready) begin
            o_spreading_factor <= i_req_sf;
            o_frames_left      <= (i_req_frames == 8'd0) ? 8'd1 : i_req_frames;
            o_req_ready        <= 1'b0;
            o_busy             <= 1'b1;
            abort_pend         <= 1'b0;
            wait_cnt           <= '0;
            state              <= WAIT_CHAOS;
          end else begin
            o_req_ready <= 1'b1;
          end
        end
        WAIT_CHAOS: begin
          if (i_abort) begin
            o_req_done <= 1'b1;
            o_busy     <= 1'b0;
            state      <= IDLE;
          end else if (i_chaos_level >= LVL_MIN) begin
            o_send <= 1'b1;
            state  <= SEND;
          end else if (wait_cnt == WAIT_LAST) begin
            o_err_timeout <= 1'b1;
            o_req_done    <= 1'b1;
            o_busy        <= 1'b0;
            state         <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        SEND: begin
          if (i_abort) abort_pend <= 1'b1;
          ack_cnt <= 1'b0;
          state   <= ACK;
        end
        ACK: begin
          if (i_abort) abort_pend <= 1'b1;
          if (i_sending) begin
            state <= BUSY;
          end else if (ack_cnt) begin
            o_err_timeout <= 1'b1;
            o_req_done    <= 1'b1;
            o_busy        <= 1'b0;
            state         <= IDLE;
          end else begin
            ack_cnt <= 1'b1;
          end
        end
        BUSY: begin
          if (sending_q && !i_sending) begin
            o_frame_done <= 1'b1;
            if (o_frames_left != 8'd0) o_frames_left <= o_frames_left - 8'd1;
            if (o_frames_left <= 8'd1 || abort_pend || i_abort) begin
              o_req_done <= 1'b1;
              o_busy     <= 1'b0;
              state      <= IDLE;
            end else begin
              gap_cnt <= '0;
              state   <= GAP;
            end
          end else if (i_abort) begin
            abort_pend <= 1'b1;
          end
        end
        GAP: begin
          if (i_abort) begin
            o_req_done <= 1'b1;
            o_busy     <= 1'b0;
            state      <= IDLE;
          end else if (gap_cnt == GAP_LAST) begin
            wait_cnt <= '0;
            state    <= WAIT_CHAOS;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// tb_tx_frame_scheduler
// Directed scenarios around a request-level reference model. The model tracks
// which phase of a frame the request is in and how long it has been there, and
// the compare process checks every DUT output against it on each falling edge.
// Literal expectations on pulse counts and spacing pin the model itself.
module tb_tx_frame_scheduler;

  localparam int LVL_W      = 8;
  localparam int MIN_CHAOS  = 16;
  localparam int WAIT_TMO   = 1024;
  localparam int GAP_CYCLES = 4;

  localparam int PH_WAIT = 0;
  localparam int PH_SEND = 1;
  localparam int PH_ACK  = 2;
  localparam int PH_RUN  = 3;
  localparam int PH_GAP  = 4;

  logic             clk = 1'b0;
  logic             i_rst = 1'b1;
  logic             i_req_valid = 1'b0;
  logic [1:0]       i_req_sf = 2'b00;
  logic [7:0]       i_req_frames = 8'd0;
  logic             i_abort = 1'b0;
  logic [LVL_W-1:0] i_chaos_level = '0;
  logic             i_sending = 1'b0;
  logic             o_req_ready, o_send, o_busy, o_frame_done, o_req_done, o_err_timeout;
  logic [1:0]       o_spreading_factor;
  logic [7:0]       o_frames_left;

  int checks_total = 0;
  int checks_pass  = 0;

  // serializer stand-in controls
  bit ser_auto = 1'b1;
  int ser_len  = 8;
  int ser_left = 0;

  // reference model state
  bit        model_valid = 1'b0;
  bit        m_act = 1'b0, m_ready = 1'b1, m_pend = 1'b0, m_prev = 1'b0;
  bit        m_send = 1'b0, m_fdone = 1'b0, m_rdone = 1'b0, m_tmo = 1'b0;
  logic [1:0] m_sf = 2'b00;
  int        m_left = 0, m_ph = 0, ph_start = 0, cyc_m = 0;

  // observed event bookkeeping (written only by the compare process)
  int cyc = 0, n_send = 0, n_fdone = 0, n_rdone = 0, n_tmo = 0, n_busy = 0;
  int send_prev = 0, send_last = 0, fdone_cyc = 0, rdone_cyc = 0, tmo_cyc = 0;
  int b_send, b_fdone, b_rdone, b_tmo, b_busy;

  tx_frame_scheduler #(
    .LVL_W(LVL_W), .MIN_CHAOS(MIN_CHAOS), .WAIT_TMO(WAIT_TMO), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .i_clk(clk),
    .i_rst(i_rst),
    .i_req_valid(i_req_valid),
    .o_req_ready(o_req_ready),
    .i_req_sf(i_req_sf),
    .i_req_frames(i_req_frames),
    .i_abort(i_abort),
    .i_chaos_level(i_chaos_level),
    .i_sending(i_sending),
    .o_send(o_send),
    .o_spreading_factor(o_spreading_factor),
    .o_busy(o_busy),
    .o_frame_done(o_frame_done),
    .o_req_done(o_req_done),
    .o_err_timeout(o_err_timeout),
    .o_frames_left(o_frames_left)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks_total++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    else
      checks_pass++;
  endtask

  // Chip counter stand-in: busy for ser_len cycles starting in the o_send cycle.
  always @(posedge clk) begin
    #1;
    if (i_rst) ser_left = 0;
    else if (o_send && ser_auto) ser_left = ser_len;
    else if (ser_left > 0) ser_left--;
    i_sending = (ser_left > 0);
  end

  task automatic modelFinish();
    m_act   = 1'b0;
    m_rdone = 1'b1;
    m_ready = 1'b0;
  endtask

  task automatic modelEnter(input int ph);
    m_ph     = ph;
    ph_start = cyc_m + 1;
  endtask

  // Reference model: steps once per rising edge on the inputs present there.
  always @(posedge clk) begin
    int n;
    m_send = 1'b0; m_fdone = 1'b0; m_rdone = 1'b0; m_tmo = 1'b0;
    if (i_rst) begin
      model_valid = 1'b1;
      m_act = 1'b0; m_ready = 1'b1; m_left = 0; m_sf = 2'b00; m_prev = 1'b0; m_pend = 1'b0;
    end else begin
      n = cyc_m - ph_start + 1;
      if (!m_act) begin
        if (m_ready && i_req_valid) begin
          m_act   = 1'b1;
          m_ready = 1'b0;
          m_sf    = i_req_sf;
          m_left  = (i_req_frames == 0) ? 1 : int'(i_req_frames);
          m_pend  = 1'b0;
          modelEnter(PH_WAIT);
        end else begin
          m_ready = 1'b1;
        end
      end else begin
        case (m_ph)
          PH_WAIT: begin
            if (i_abort) modelFinish();
            else if (int'(i_chaos_level) >= MIN_CHAOS) begin m_send = 1'b1; modelEnter(PH_SEND); end
            else if (n == WAIT_TMO) begin m_tmo = 1'b1; modelFinish(); end
          end
          PH_SEND: begin
            if (i_abort) m_pend = 1'b1;
            modelEnter(PH_ACK);
          end
          PH_ACK: begin
            if (i_abort) m_pend = 1'b1;
            if (i_sending) modelEnter(PH_RUN);
            else if (n == 2) begin m_tmo = 1'b1; modelFinish(); end
          end
          PH_RUN: begin
            if (i_abort) m_pend = 1'b1;
            if (m_prev && !i_sending) begin
              m_fdone = 1'b1;
              if (m_left > 0) m_left--;
              if (m_left == 0 || m_pend) modelFinish();
              else modelEnter(PH_GAP);
            end
          end
          default: begin
            if (i_abort) modelFinish();
            else if (n == GAP_CYCLES) modelEnter(PH_WAIT);
          end
        endcase
      end
      m_prev = i_sending;
    end
    cyc_m++;
  end

  // Compare every output against the model and log the observed events.
  always @(negedge clk) begin
    if (model_valid) begin
      checkOutput("req_ready", o_req_ready, m_ready);
      checkOutput("busy", o_busy, m_act);
      checkOutput("send", o_send, m_send);
      checkOutput("spreading_factor", o_spreading_factor, m_sf);
      checkOutput("frame_done", o_frame_done, m_fdone);
      checkOutput("req_done", o_req_done, m_rdone);
      checkOutput("err_timeout", o_err_timeout, m_tmo);
      checkOutput("frames_left", o_frames_left, m_left);
    end
    cyc++;
    if (o_send === 1'b1) begin n_send++; send_prev = send_last; send_last = cyc; end
    if (o_frame_done === 1'b1) begin n_fdone++; fdone_cyc = cyc; end
    if (o_req_done === 1'b1) begin n_rdone++; rdone_cyc = cyc; end
    if (o_err_timeout === 1'b1) begin n_tmo++; tmo_cyc = cyc; end
    if (o_busy === 1'b1) n_busy++;
  end

  task automatic snapshot();
    b_send = n_send; b_fdone = n_fdone; b_rdone = n_rdone; b_tmo = n_tmo; b_busy = n_busy;
  endtask

  task automatic checkCounts(input string tag, input int sends, input int fdones, input int rdones, input int tmos);
    checkOutput({tag, "_sends"}, n_send - b_send, sends);
    checkOutput({tag, "_frame_dones"}, n_fdone - b_fdone, fdones);
    checkOutput({tag, "_req_dones"}, n_rdone - b_rdone, rdones);
    checkOutput({tag, "_timeouts"}, n_tmo - b_tmo, tmos);
  endtask

  // Present one request once ready is seen; returns on the falling edge after acceptance.
  task automatic applyStimulus(input logic [1:0] sf, input logic [7:0] frames);
    int guard = 0;
    @(negedge clk);
    while (o_req_ready !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
    if (o_req_ready !== 1'b1) checkOutput("ready_wait", o_req_ready, 1);
    i_req_valid  = 1'b1;
    i_req_sf     = sf;
    i_req_frames = frames;
    @(negedge clk);
    i_req_valid  = 1'b0;
    i_req_sf     = ~sf;
    i_req_frames = 8'hA5;
  endtask

  task automatic waitIdle(input int max_cycles);
    int n = 0;
    do begin @(negedge clk); n++; end
    while ((o_busy !== 1'b0 || o_req_ready !== 1'b1) && n < max_cycles);
    if (o_busy !== 1'b0 || o_req_ready !== 1'b1) begin
      checkOutput("idle_wait_busy", o_busy, 0);
      checkOutput("idle_wait_ready", o_req_ready, 1);
    end
  endtask

  task automatic waitSending(input int max_cycles);
    int n = 0;
    while (i_sending !== 1'b1 && n < max_cycles) begin @(negedge clk); n++; end
    if (i_sending !== 1'b1) checkOutput("sending_wait", i_sending, 1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    checkOutput("rst_ready", o_req_ready, 1);
    checkOutput("rst_busy", o_busy, 0);
    checkOutput("rst_frames_left", o_frames_left, 0);
    checkOutput("rst_sf", o_spreading_factor, 0);
    i_rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_ready", o_req_ready, 1);

    // single frame, SF4, long serializer activity
    i_chaos_level = 8'd20;
    ser_len = 256;
    snapshot();
    applyStimulus(2'b01, 8'd1);
    checkOutput("s1_frames_left_busy", o_frames_left, 1);
    checkOutput("s1_sf_held", o_spreading_factor, 2'b01);
    waitIdle(600);
    checkCounts("s1", 1, 1, 1, 0);
    checkOutput("s1_done_together", rdone_cyc, fdone_cyc);
    checkOutput("s1_frames_left_end", o_frames_left, 0);

    // three frames with guard gap
    ser_len = 8;
    snapshot();
    applyStimulus(2'b10, 8'd3);
    waitIdle(300);
    checkCounts("s2", 3, 3, 1, 0);
    checkOutput("s2_send_spacing", send_last - send_prev, 8 + GAP_CYCLES + 2);

    // chaos level never sufficient
    i_chaos_level = 8'd10;
    snapshot();
    applyStimulus(2'b00, 8'd1);
    waitIdle(1100);
    checkCounts("s3", 0, 0, 1, 1);
    checkOutput("s3_wait_cycles", n_busy - b_busy, WAIT_TMO);

    // threshold met exactly
    i_chaos_level = 8'd16;
    snapshot();
    applyStimulus(2'b11, 8'd1);
    waitIdle(100);
    checkCounts("s3b", 1, 1, 1, 0);

    // serializer never acknowledges
    i_chaos_level = 8'd20;
    ser_auto = 1'b0;
    snapshot();
    applyStimulus(2'b01, 8'd2);
    waitIdle(50);
    ser_auto = 1'b1;
    checkCounts("s4", 1, 0, 1, 1);
    checkOutput("s4_ack_timeout_delay", tmo_cyc - send_last, 3);

    // abort in the same cycle the threshold is met
    snapshot();
    applyStimulus(2'b01, 8'd2);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    waitIdle(20);
    checkCounts("s5a", 0, 0, 1, 0);

    // abort while frame 1 of 3 is on air
    ser_len = 20;
    snapshot();
    applyStimulus(2'b10, 8'd3);
    waitSending(20);
    repeat (3) @(negedge clk);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    waitIdle(100);
    checkCounts("s5b", 1, 1, 1, 0);
    checkOutput("s5b_done_together", rdone_cyc, fdone_cyc);
    checkOutput("s5b_frames_left", o_frames_left, 2);

    // abort during the guard gap
    ser_len = 8;
    snapshot();
    applyStimulus(2'b01, 8'd3);
    n = 0;
    while (o_frame_done !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (o_frame_done !== 1'b1) checkOutput("gap_wait", o_frame_done, 1);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    waitIdle(20);
    checkCounts("s5c", 1, 1, 1, 0);
    checkOutput("s5c_done_delay", rdone_cyc - fdone_cyc, 1);

    // abort while idle has no effect
    i_abort = 1'b1;
    repeat (2) @(negedge clk);
    i_abort = 1'b0;
    checkOutput("idle_abort_busy", o_busy, 0);

    // zero frames means one
    snapshot();
    applyStimulus(2'b10, 8'd0);
    checkOutput("s6_frames_left_busy", o_frames_left, 1);
    waitIdle(100);
    checkCounts("s6", 1, 1, 1, 0);

    // reset in the middle of a frame
    ser_len = 50;
    snapshot();
    applyStimulus(2'b11, 8'd3);
    waitSending(20);
    repeat (3) @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_busy", o_busy, 0);
    checkOutput("midrst_ready", o_req_ready, 1);
    checkOutput("midrst_frames_left", o_frames_left, 0);
    checkOutput("midrst_sf", o_spreading_factor, 0);
    checkOutput("midrst_send", o_send, 0);
    i_rst = 1'b0;
    repeat (3) @(negedge clk);
    checkCounts("s6b", 1, 0, 0, 0);
    checkOutput("s6b_ready", o_req_ready, 1);

    $display("%0d/%0d checks passed", checks_pass, checks_total);
    $finish;
  end

endmodule
